dff_share_arb: RTL and testbench



---
 rtl/dff_share_arb_if.sv | 36 +++
 rtl/dff_share_arb.sv | 139 +++++++++++++
 tb/tb_dff_share_arb.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dff_share_arb_if.sv
// Bus between N producers and the shared-register arbiter: per-requester
// request/lock/data in, shared register contents plus grant/ack status out.
interface dff_share_arb_if #(
    parameter int N = 4,
    parameter int W = 8
);
    logic [N-1:0]   req;
    logic [N-1:0]   lock;
    logic [N*W-1:0] din;
    logic [W-1:0]   q;
    logic [N-1:0]   gnt;
    logic [N-1:0]   ack;
    logic           busy;

    // Producer side
    modport master (
        output req,
        output lock,
        output din,
        input  q,
        input  gnt,
        input  ack,
        input  busy
    );

    // Arbiter side
    modport slave (
        input  req,
        input  lock,
        input  din,
        output q,
        output gnt,
        output ack,
        output busy
    );
endinterface

// File: rtl/dff_share_arb.sv
// Round-robin arbiter sharing one W-bit register among N requesters.
// The current owner's data is written on each edge it holds req; the grant is
// kept only while the owner holds both req and lock, otherwise it is handed
// straight to the next pending requester (searching from owner+1) with no
// idle bubble, or dropped back to idle.
module dff_share_arb #(
    parameter int N = 4,
    parameter int W = 8
) (
    input  logic            clk,
    input  logic            rst,
    dff_share_arb_if.slave  bus
);
    localparam int PW = $clog2(N);

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] owner_q, owner_d;
    logic [PW-1:0] ptr_q,   ptr_d;
    logic [W-1:0]  data_q,  data_d;
    logic [N-1:0]  gnt_q,   gnt_d;
    logic [N-1:0]  ack_q,   ack_d;

    logic [W-1:0]  din_arr [N];
    logic [PW-1:0] owner_inc;
    logic [N-1:0]  search_mask;
    logic [PW-1:0] search_start;
    logic          found;
    logic [PW-1:0] found_idx;

    // Unpack the flattened data bus into one slice per requester
    for (genvar gi = 0; gi < N; gi++) begin : g_din
        assign din_arr[gi] = bus.din[gi*W +: W];
    end

    // Index following the owner, wrapping at N-1
    assign owner_inc = (owner_q == PW'(N-1)) ? '0 : owner_q + PW'(1);

    // Choose who takes part in the search and where the search starts:
    // from ptr when idle, from owner+1 with the owner masked out on release
    always_comb begin
        search_mask  = bus.req;
        search_start = ptr_q;
        if (state_q == OWN) begin
            search_mask[owner_q] = 1'b0;
            search_start         = owner_inc;
        end
    end

    // Rotating priority search: first set mask bit at or after search_start
    always_comb begin
        int unsigned   p;
        logic [PW-1:0] pi;
        found     = 1'b0;
        found_idx = '0;
        p         = 0;
        pi        = '0;
        // Walk offsets from far to near so the nearest match is the last write
        for (int k = N-1; k >= 0; k--) begin
            p = int'(search_start) + k;
            if (p >= N) begin
                p = p - N;
            end
            pi = PW'(p);
            if (search_mask[pi]) begin
                found     = 1'b1;
                found_idx = pi;
            end
        end
    end

    // Next-state: write, acknowledge, keep/release/hand off the grant
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        data_d  = data_q;
        ack_d   = '0;
        gnt_d   = '0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = OWN;
                    owner_d = found_idx;
                end
            end
            OWN: begin
                if (bus.req[owner_q]) begin
                    data_d         = din_arr[owner_q];
                    ack_d[owner_q] = 1'b1;
                end
                // Keep only when the owner both wrote and holds its lock
                if (!(bus.req[owner_q] && bus.lock[owner_q])) begin
                    ptr_d = owner_inc;
                    if (found) begin
                        owner_d = found_idx;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (state_d == OWN) begin
            gnt_d[owner_d] = 1'b1;
        end
    end

    // State, pointer, shared register and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            data_q  <= '0;
            gnt_q   <= '0;
            ack_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            data_q  <= data_d;
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
        end
    end

    assign bus.q    = data_q;
    assign bus.gnt  = gnt_q;
    assign bus.ack  = ack_q;
    assign bus.busy = |gnt_q;

endmodule

// File: tb/tb_dff_share_arb.sv
// Directed bench for dff_share_arb (N=4, W=8): reset, single write,
// round-robin order, locked streaming, withdrawal, asynchronous reset.
module tb_dff_share_arb;
    logic clk;
    logic rst;
    int   vectors = 0;
    int   errors  = 0;

    dff_share_arb_if #(.N(4), .W(8)) bus ();

    dff_share_arb #(.N(4), .W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_din(input int i, input logic [7:0] v);
        bus.din[i*8 +: 8] = v;
    endtask

    task automatic do_reset();
        bus.req  = '0;
        bus.lock = '0;
        bus.din  = '0;
        rst      = 1'b1;
        tick();
        tick();
        rst      = 1'b0;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        bus.req  = '0;
        bus.lock = '0;
        bus.din  = '0;
        for (int c = 0; c < 5; c++) begin
            tick();
            vectors++;
            if ({bus.q, bus.gnt, bus.ack, bus.busy} !== 17'd0) begin
                $display("FAIL reset_c%0d: got q=%h gnt=%b ack=%b busy=%b want all zero",
                         c, bus.q, bus.gnt, bus.ack, bus.busy);
                errors++;
            end
        end
        rst = 1'b0;
        $display("reset: held 5 cycles, q=%h gnt=%b", bus.q, bus.gnt);
    endtask

    task automatic test_single();
        do_reset();
        set_din(2, 8'hA5);
        bus.req = 4'b0100;
        tick();
        vectors++;
        if ({bus.gnt, bus.ack, bus.q} !== {4'b0100, 4'b0000, 8'h00}) begin
            $display("FAIL single_grant: got gnt=%b ack=%b q=%h want gnt=0100 ack=0000 q=00",
                     bus.gnt, bus.ack, bus.q);
            errors++;
        end
        tick();
        vectors++;
        if ({bus.gnt, bus.ack, bus.q} !== {4'b0000, 4'b0100, 8'hA5}) begin
            $display("FAIL single_write: got gnt=%b ack=%b q=%h want gnt=0000 ack=0100 q=a5",
                     bus.gnt, bus.ack, bus.q);
            errors++;
        end
        bus.req = 4'b0000;
        tick();
        vectors++;
        if ({bus.gnt, bus.ack, bus.q, bus.busy} !== {4'b0000, 4'b0000, 8'hA5, 1'b0}) begin
            $display("FAIL single_idle: got gnt=%b ack=%b q=%h busy=%b want 0000 0000 a5 0",
                     bus.gnt, bus.ack, bus.q, bus.busy);
            errors++;
        end
        $display("single: requester 2 wrote q=%h", bus.q);
    endtask

    task automatic test_round_robin();
        logic [7:0] exp_q;
        logic [3:0] exp_ack;
        logic [3:0] exp_gnt;
        do_reset();
        for (int i = 0; i < 4; i++) set_din(i, 8'h10 + 8'(i));
        bus.req = 4'b1111;
        tick();
        vectors++;
        if (bus.gnt !== 4'b0001) begin
            $display("FAIL rr_first_grant: got gnt=%b want 0001", bus.gnt);
            errors++;
        end
        for (int k = 0; k < 5; k++) begin
            tick();
            exp_q   = 8'h10 + 8'(k % 4);
            exp_ack = 4'b0001 << (k % 4);
            exp_gnt = 4'b0001 << ((k + 1) % 4);
            vectors++;
            if ({bus.q, bus.ack, bus.gnt} !== {exp_q, exp_ack, exp_gnt}) begin
                $display("FAIL rr_write%0d: got q=%h ack=%b gnt=%b want q=%h ack=%b gnt=%b",
                         k, bus.q, bus.ack, bus.gnt, exp_q, exp_ack, exp_gnt);
                errors++;
            end
            $display("rr: write %0d q=%h ack=%b next gnt=%b", k, bus.q, bus.ack, bus.gnt);
        end
        bus.req = '0;
    endtask

    task automatic test_lock_stream();
        logic [3:0] exp_gnt;
        do_reset();
        set_din(1, 8'h01);
        set_din(3, 8'hC3);
        bus.req  = 4'b1010;
        bus.lock = 4'b0010;
        tick();
        vectors++;
        if (bus.gnt !== 4'b0010) begin
            $display("FAIL lock_grant: got gnt=%b want 0010", bus.gnt);
            errors++;
        end
        for (int k = 1; k <= 3; k++) begin
            set_din(1, 8'(k));
            if (k == 3) bus.lock = 4'b0000;
            tick();
            exp_gnt = (k < 3) ? 4'b0010 : 4'b1000;
            vectors++;
            if ({bus.q, bus.ack, bus.gnt} !== {8'(k), 4'b0010, exp_gnt}) begin
                $display("FAIL lock_write%0d: got q=%h ack=%b gnt=%b want q=%h ack=0010 gnt=%b",
                         k, bus.q, bus.ack, bus.gnt, 8'(k), exp_gnt);
                errors++;
            end
            $display("lock: write %0d q=%h gnt=%b", k, bus.q, bus.gnt);
        end
        bus.req = 4'b1000;
        tick();
        vectors++;
        if ({bus.q, bus.ack, bus.gnt} !== {8'hC3, 4'b1000, 4'b0000}) begin
            $display("FAIL lock_handoff_write: got q=%h ack=%b gnt=%b want q=c3 ack=1000 gnt=0000",
                     bus.q, bus.ack, bus.gnt);
            errors++;
        end
        bus.req = '0;
    endtask

    task automatic test_withdraw();
        do_reset();
        set_din(0, 8'h77);
        set_din(1, 8'h5A);
        bus.req = 4'b0001;
        tick();
        vectors++;
        if (bus.gnt !== 4'b0001) begin
            $display("FAIL wd_grant: got gnt=%b want 0001", bus.gnt);
            errors++;
        end
        bus.req = 4'b0000;
        tick();
        vectors++;
        if ({bus.q, bus.ack, bus.gnt} !== {8'h00, 4'b0000, 4'b0000}) begin
            $display("FAIL wd_release: got q=%h ack=%b gnt=%b want q=00 ack=0000 gnt=0000",
                     bus.q, bus.ack, bus.gnt);
            errors++;
        end
        // ptr moved past 0, so 1 beats 0 in a tie
        bus.req = 4'b0011;
        tick();
        vectors++;
        if (bus.gnt !== 4'b0010) begin
            $display("FAIL wd_ptr: got gnt=%b want 0010", bus.gnt);
            errors++;
        end
        bus.req = 4'b0010;
        tick();
        vectors++;
        if ({bus.q, bus.ack, bus.gnt} !== {8'h5A, 4'b0010, 4'b0000}) begin
            $display("FAIL wd_write1: got q=%h ack=%b gnt=%b want q=5a ack=0010 gnt=0000",
                     bus.q, bus.ack, bus.gnt);
            errors++;
        end
        bus.req = '0;
        $display("withdraw: q=%h after requester 1 write", bus.q);
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.req  = 4'b0010;
        bus.lock = 4'b0010;
        set_din(1, 8'h01);
        tick();
        for (int k = 1; k <= 3; k++) begin
            set_din(1, 8'(k));
            tick();
        end
        vectors++;
        if ({bus.q, bus.gnt} !== {8'h03, 4'b0010}) begin
            $display("FAIL mid_pre: got q=%h gnt=%b want q=03 gnt=0010", bus.q, bus.gnt);
            errors++;
        end
        #3;
        rst = 1'b1;
        #1;
        vectors++;
        if ({bus.q, bus.gnt, bus.ack, bus.busy} !== 17'd0) begin
            $display("FAIL mid_async: got q=%h gnt=%b ack=%b busy=%b want all zero",
                     bus.q, bus.gnt, bus.ack, bus.busy);
            errors++;
        end
        bus.req  = '0;
        bus.lock = '0;
        tick();
        rst = 1'b0;
        set_din(2, 8'h22);
        set_din(3, 8'h33);
        bus.req = 4'b1100;
        tick();
        vectors++;
        if (bus.gnt !== 4'b0100) begin
            $display("FAIL mid_regrant: got gnt=%b want 0100", bus.gnt);
            errors++;
        end
        tick();
        vectors++;
        if ({bus.q, bus.ack, bus.gnt} !== {8'h22, 4'b0100, 4'b1000}) begin
            $display("FAIL mid_handoff: got q=%h ack=%b gnt=%b want q=22 ack=0100 gnt=1000",
                     bus.q, bus.ack, bus.gnt);
            errors++;
        end
        // Owner 3 withdraws: no write, no ack
        bus.req = 4'b0000;
        tick();
        vectors++;
        if ({bus.q, bus.ack, bus.gnt} !== {8'h22, 4'b0000, 4'b0000}) begin
            $display("FAIL mid_withdraw: got q=%h ack=%b gnt=%b want q=22 ack=0000 gnt=0000",
                     bus.q, bus.ack, bus.gnt);
            errors++;
        end
        $display("reset_mid: q=%h after recovery", bus.q);
    endtask

    initial begin
        rst      = 1'b1;
        bus.req  = '0;
        bus.lock = '0;
        bus.din  = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_lock_stream();
        test_withdraw();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
